// File: rtl/pixel_readback.sv
// pixel_readback: framebuffer written through a VGA-style plot port and
// read back in raster order over a valid/ready stream.
module pixel_readback #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120,
  parameter int unsigned CW     = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    vga_x,
  input  logic [6:0]    vga_y,
  input  logic [CW-1:0] vga_colour,
  input  logic          vga_plot,
  input  logic          start,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [7:0]    rd_x,
  output logic [6:0]    rd_y,
  output logic [CW-1:0] rd_colour,
  output logic          busy,
  output logic          done,
  output logic [14:0]   plot_count,
  output logic [7:0]    oob_count
);

  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] mem [DEPTH];

  logic          in_range;
  logic          wr_en;
  logic          handshake;
  logic          last_px;
  logic          x_last;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign in_range  = (32'(vga_x) < WIDTH) && (32'(vga_y) < HEIGHT);
  // Writes are ignored while reset is asserted; memory itself is never cleared.
  assign wr_en     = vga_plot && in_range && rst_n;
  assign wr_addr   = AW'(32'(vga_y) * WIDTH + 32'(vga_x));
  assign rd_addr   = AW'(32'(rd_y) * WIDTH + 32'(rd_x));
  assign x_last    = (32'(rd_x) == WIDTH - 1);
  assign last_px   = x_last && (32'(rd_y) == HEIGHT - 1);
  assign handshake = (state == S_PRESENT) && rd_ready;

  assign rd_valid  = (state == S_PRESENT);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Framebuffer write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= vga_colour;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic for the raster scan.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (start) state_next = S_FETCH;
      S_FETCH:   state_next = S_PRESENT;
      S_PRESENT: if (handshake) state_next = last_px ? S_DONE : S_FETCH;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Scan pointer and read-port register; rd_x/rd_y double as the pointer.
  // The read is non-blocking, so a same-edge write to the fetched address
  // returns the old colour, and rd_colour only changes in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_x      <= '0;
      rd_y      <= '0;
      rd_colour <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            rd_x <= '0;
            rd_y <= '0;
          end
        end
        S_FETCH: rd_colour <= mem[rd_addr];
        S_PRESENT: begin
          if (handshake && !last_px) begin
            if (x_last) begin
              rd_x <= '0;
              rd_y <= rd_y + 7'd1;
            end else begin
              rd_x <= rd_x + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating plot counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plot_count <= '0;
      oob_count  <= '0;
    end else if (vga_plot) begin
      if (in_range) begin
        if (plot_count != '1) plot_count <= plot_count + 15'd1;
      end else begin
        if (oob_count != '1) oob_count <= oob_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_readback.sv
// Self-checking bench for pixel_readback: table-driven plot vectors, a
// reference framebuffer/counter model, and randomized readback scans.
module tb_pixel_readback;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       start;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic [2:0] rd_colour;
  logic       busy;
  logic       done;
  logic [14:0] plot_count;
  logic [7:0]  oob_count;

  pixel_readback #(.WIDTH(W), .HEIGHT(H), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .start(start), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y), .rd_colour(rd_colour),
    .busy(busy), .done(done), .plot_count(plot_count), .oob_count(oob_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: framebuffer contents and counter values.
  int fb [N];
  int mplot;
  int moob;

  typedef struct {
    int x;
    int y;
    int c;
    bit plot;
    int exp_plot;
    int exp_oob;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void model_write(input int x, input int y, input int c);
    if (x < W && y < H) begin
      fb[y * W + x] = c;
      if (mplot < 32767) mplot++;
    end else begin
      if (moob < 255) moob++;
    end
  endfunction

  // Call right after a falling edge; takes effect at the next rising edge.
  task automatic drive_plot(input int x, input int y, input int c);
    vga_x      = 8'(x);
    vga_y      = 7'(y);
    vga_colour = 3'(c);
    vga_plot   = 1'b1;
    model_write(x, y, c);
  endtask

  // Reset in the middle of a scan; a plot held during reset must be dropped.
  task automatic do_abort();
    int x;
    x          = int'($urandom_range(99));
    rst_n      = 1'b0;
    vga_x      = 8'(x);
    vga_y      = 7'd0;
    vga_colour = 3'(fb[x] ^ 7);
    vga_plot   = 1'b1;
    rd_ready   = 1'b0;
    start      = 1'b0;
    #1;
    check("abort_rd_valid", int'(rd_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    check("abort_done_held", int'(done), 0);
    rst_n    = 1'b1;
    vga_plot = 1'b0;
    mplot    = 0;
    moob     = 0;
    @(negedge clk);
    check("abort_plot_count", int'(plot_count), mplot);
    check("abort_oob_count", int'(oob_count), moob);
    check("abort_idle", int'(busy), 0);
  endtask

  function automatic int pack_px(input int x, input int y, input int c);
    return (x << 10) | (y << 3) | c;
  endfunction

  // Raster readback against the model. Writes only target pixels at or
  // before the current one, so the expected colour of each pixel is the
  // model value at the moment the scan reaches it.
  task automatic run_scan(input int ready_pct, input int abort_at,
                          input int restart_at, input int wr_pct);
    int  cur;
    int  cyc;
    int  exp_c;
    int  first_valid;
    int  early_done;
    int  end_cyc;
    bit  restarted;
    bit  hs;
    int  a;
    cur = 0; cyc = 0; first_valid = -1; early_done = 0; end_cyc = -1;
    restarted = 1'b0;
    @(negedge clk);
    vga_plot = 1'b0;
    rd_ready = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    exp_c = fb[0];
    while (cyc < 90000) begin
      @(negedge clk);
      if (abort_at >= 0 && cur == abort_at) begin
        check("no_early_done", early_done, 0);
        check("first_valid_latency", first_valid, 1);
        do_abort();
        return;
      end
      if (cur == N) begin
        check("done_pulse", int'(done), 1);
        check("done_busy", int'(busy), 1);
        check("done_rd_valid", int'(rd_valid), 0);
        vga_plot = 1'b0;
        rd_ready = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("busy_after_done", int'(busy), 0);
        check("no_early_done", early_done, 0);
        check("first_valid_latency", first_valid, 1);
        if (ready_pct >= 100) check("frame_cycles", end_cyc, 2 * N);
        return;
      end
      if (cyc == 0) check("busy_after_start", int'(busy), 1);
      if (done) early_done++;
      if (rd_valid) begin
        if (first_valid < 0) first_valid = cyc;
        check("pixel", pack_px(int'(rd_x), int'(rd_y), int'(rd_colour)),
              pack_px(cur % W, cur / W, exp_c));
      end
      start = (cur == restart_at) && !restarted;
      if (start) restarted = 1'b1;
      rd_ready = (int'($urandom_range(99)) < ready_pct);
      if (int'($urandom_range(99)) < wr_pct) begin
        if ($urandom_range(3) == 0) begin
          drive_plot(W + int'($urandom_range(255 - W)), int'($urandom_range(127)),
                     int'($urandom_range(7)));
        end else begin
          a = int'($urandom_range(cur));
          drive_plot(a % W, a / W, int'($urandom_range(7)));
        end
      end else begin
        vga_plot = 1'b0;
      end
      hs = rd_valid && rd_ready;
      @(posedge clk);
      cyc++;
      if (hs) begin
        cur++;
        if (cur < N) exp_c = fb[cur];
        else end_cyc = cyc;
      end
    end
    check("scan_progress", cur, N);
  endtask

  initial begin
    int old_c;
    int new_c;

    vecs[0] = '{5,   3,   5, 1'b1, 1, 0};
    vecs[1] = '{159, 119, 2, 1'b1, 2, 0};
    vecs[2] = '{160, 0,   7, 1'b1, 2, 1};
    vecs[3] = '{0,   120, 7, 1'b1, 2, 2};
    vecs[4] = '{255, 127, 7, 1'b1, 2, 3};
    vecs[5] = '{0,   0,   4, 1'b1, 3, 3};
    vecs[6] = '{10,  10,  1, 1'b0, 3, 3};
    vecs[7] = '{159, 0,   6, 1'b1, 4, 3};
    vecs[8] = '{0,   119, 3, 1'b1, 5, 3};

    rst_n = 1'b1; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
    start = 1'b0; rd_ready = 1'b0;
    mplot = 0; moob = 0;
    for (int i = 0; i < N; i++) fb[i] = 0;

    // Reset values.
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_x", int'(rd_x), 0);
    check("rst_rd_y", int'(rd_y), 0);
    check("rst_rd_colour", int'(rd_colour), 0);
    check("rst_plot_count", int'(plot_count), 0);
    check("rst_oob_count", int'(oob_count), 0);
    rst_n = 1'b1;

    // Fill the frame with (x+y) mod 8.
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        @(negedge clk);
        drive_plot(x, y, (x + y) % 8);
      end
    end
    @(negedge clk);
    vga_plot = 1'b0;
    @(negedge clk);
    check("fill_plot_count", int'(plot_count), N);

    // Reset clears counters but not memory.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mplot = 0;
    moob  = 0;
    @(negedge clk);
    check("rst2_plot_count", int'(plot_count), 0);

    // Table of plots including coordinate boundaries.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (vecs[i].plot) drive_plot(vecs[i].x, vecs[i].y, vecs[i].c);
      else begin
        vga_x = 8'(vecs[i].x); vga_y = 7'(vecs[i].y); vga_colour = 3'(vecs[i].c);
        vga_plot = 1'b0;
      end
      @(negedge clk);
      vga_plot = 1'b0;
      check($sformatf("vec%0d_plot_count", i), int'(plot_count), vecs[i].exp_plot);
      check($sformatf("vec%0d_oob_count", i), int'(oob_count), vecs[i].exp_oob);
    end

    // oob counter saturation.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive_plot(W + int'($urandom_range(255 - W)), int'($urandom_range(127)),
                 int'($urandom_range(7)));
    end
    @(negedge clk);
    vga_plot = 1'b0;
    @(negedge clk);
    check("oob_saturate", int'(oob_count), 255);
    check("oob_no_plot", int'(plot_count), 5);

    // Read back through pixel 485 (5,3), then abandon by reset.
    run_scan(100, 486, -1, 0);

    // Same-edge write to the fetched pixel, then a write while presented.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    old_c = fb[0];
    new_c = old_c ^ 7;
    drive_plot(0, 0, new_c);
    @(posedge clk);
    @(negedge clk);
    check("same_addr_valid", int'(rd_valid), 1);
    check("same_addr_old", int'(rd_colour), old_c);
    drive_plot(0, 0, old_c ^ 5);
    @(posedge clk);
    @(negedge clk);
    vga_plot = 1'b0;
    check("presented_stable", int'(rd_colour), old_c);
    check("presented_valid_held", int'(rd_valid), 1);
    do_abort();

    // Random stalls and writes, reset at pixel 1000.
    run_scan(50, 1000, -1, 30);
    // Restart after abort begins at (0,0).
    run_scan(100, 2, -1, 0);
    // Full frame, second start mid-scan must be ignored.
    run_scan(100, -1, 500, 20);

    check("final_plot_count", int'(plot_count), mplot);
    check("final_oob_count", int'(oob_count), moob);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
